// File: rtl/softmax_pkg.sv
// Shared types and helpers for the I-BERT softmax pipeline stages.
// The width and length defaults here are also used by the downstream exponent stage.
package softmax_pkg;

  localparam int D_W_DEF     = 32;
  localparam int MAX_LEN_DEF = 64;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // Sign-extended operands let a single 64-bit subtract cover any D_W+1-bit
  // difference. Only the lower bound is clamped because a - row_max is never positive.
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int              w);
    logic signed [63:0] diff;
    logic signed [63:0] lo;
    diff = a - b;
    lo   = -(64'sd1 <<< (w - 1));
    return (diff < lo) ? lo : diff;
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Row storage for max_subtract: synchronous write, combinational read by index.
// Contents are deliberately not reset; the write counter defines which entries are valid.
module row_buffer #(
  parameter int D_W    = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic        [ADDR_W-1:0] wr_addr,
  input  logic signed [D_W-1:0]    wr_data,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic signed [D_W-1:0]    rd_data
);

  logic signed [D_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_subtract.sv
// Softmax pre-stage: buffers one row of scores while tracking its maximum,
// then replays each element as a saturated (x - row_max).
module max_subtract
  import softmax_pkg::*;
#(
  parameter int D_W     = D_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [D_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [D_W-1:0] out_data,
  output logic                  out_last
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t                state_reg, state_next;
  logic [LEN_W-1:0]      wr_cnt_reg, wr_cnt_next;
  logic [LEN_W-1:0]      rd_cnt_reg, rd_cnt_next;
  logic [LEN_W-1:0]      len_reg, len_next;
  logic signed [D_W-1:0] row_max_reg, row_max_next;
  logic signed [D_W-1:0] out_data_reg, out_data_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_last_reg, out_last_next;

  logic                  in_fire;
  logic                  out_fire;
  logic                  row_end;
  logic [LEN_W-1:0]      rd_cnt_inc;
  logic [ADDR_W-1:0]     rd_addr;
  logic signed [D_W-1:0] rd_data;
  logic signed [D_W-1:0] first_elem;
  logic signed [D_W-1:0] max_upd;

  assign in_ready   = (state_reg == S_FILL) && !rst;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_reg && out_ready;
  assign row_end    = in_last || (wr_cnt_reg == LEN_W'(MAX_LEN - 1));
  assign rd_cnt_inc = rd_cnt_reg + LEN_W'(1);

  // While filling, port reads entry 0 so the first drain output can be formed on
  // the final input beat; while draining it looks one element ahead.
  assign rd_addr    = (state_reg == S_FILL) ? '0 : rd_cnt_inc[ADDR_W-1:0];
  assign first_elem = (wr_cnt_reg == '0) ? in_data : rd_data;
  assign max_upd    = ((wr_cnt_reg == '0) || (in_data > row_max_reg)) ? in_data : row_max_reg;

  row_buffer #(
    .D_W   (D_W),
    .DEPTH (MAX_LEN),
    .ADDR_W(ADDR_W)
  ) u_row_buffer (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_addr(wr_cnt_reg[ADDR_W-1:0]),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_next     = state_reg;
    wr_cnt_next    = wr_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    len_next       = len_reg;
    row_max_next   = row_max_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    case (state_reg)
      S_FILL: begin
        if (in_fire) begin
          wr_cnt_next  = wr_cnt_reg + LEN_W'(1);
          row_max_next = max_upd;
          if (row_end) begin
            state_next     = S_DRAIN;
            len_next       = wr_cnt_reg + LEN_W'(1);
            wr_cnt_next    = '0;
            rd_cnt_next    = '0;
            out_valid_next = 1'b1;
            out_data_next  = D_W'(sat_sub(64'(first_elem), 64'(max_upd), D_W));
            out_last_next  = (wr_cnt_reg == '0);
          end
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (out_last_reg) begin
            state_next     = S_FILL;
            rd_cnt_next    = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            out_data_next  = '0;
          end else begin
            rd_cnt_next   = rd_cnt_inc;
            out_data_next = D_W'(sat_sub(64'(rd_data), 64'(row_max_reg), D_W));
            out_last_next = (rd_cnt_inc == len_reg - LEN_W'(1));
          end
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FILL;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      len_reg       <= '0;
      row_max_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      len_reg       <= len_next;
      row_max_reg   <= row_max_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_max_subtract.sv
// Bench for max_subtract: a 32-bit/64-deep instance and an 8-bit/4-deep instance,
// driven from a table of rows plus a hand-written reset-during-drain sequence.
module tb_max_subtract;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic signed [31:0] a_in_data, a_out_data;
  logic              b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic signed [7:0]  b_in_data, b_out_data;

  max_subtract u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  max_subtract #(.D_W(8), .MAX_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int          sel;
    int          n;
    int          din[4];
    bit          last;
    int          dout[4];
    logic [15:0] pat;
    bit          junk;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive_in(input int sel, input bit v, input int d, input bit l);
    if (sel == 0) begin
      a_in_valid = v; a_in_data = d; a_in_last = l;
    end else begin
      b_in_valid = v; b_in_data = d[7:0]; b_in_last = l;
    end
  endtask

  task automatic drive_rdy(input int sel, input bit r);
    if (sel == 0) a_out_ready = r;
    else          b_out_ready = r;
  endtask

  function automatic bit ov(input int sel);
    return (sel == 0) ? a_out_valid : b_out_valid;
  endfunction

  function automatic bit ol(input int sel);
    return (sel == 0) ? a_out_last : b_out_last;
  endfunction

  function automatic bit ir(input int sel);
    return (sel == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic int od(input int sel);
    int r;
    if (sel == 0) r = a_out_data;
    else          r = b_out_data;
    return r;
  endfunction

  // Feeds one row, then drains it with the given out_ready pattern and checks
  // latency, values, out_last, stall stability and the inter-row bubble.
  task automatic run_row(input vec_t v);
    int k;
    int cyc;
    bit rdy;
    bit stalled;
    int prev_d;
    bit prev_l;
    @(posedge clk); #1;
    for (int i = 0; i < v.n; i++) begin
      drive_in(v.sel, 1'b1, v.din[i], v.last && (i == v.n - 1));
      @(negedge clk);
      check($sformatf("%s fill in_ready[%0d]", v.name, i), ir(v.sel), 1);
      @(posedge clk); #1;
    end
    drive_in(v.sel, 1'b0, 0, 1'b0);
    rdy = v.pat[0];
    drive_rdy(v.sel, rdy);
    @(negedge clk);
    check($sformatf("%s first out_valid latency", v.name), ov(v.sel), 1);
    k = 0; cyc = 0; stalled = 1'b0; prev_d = 0; prev_l = 1'b0;
    while (k < v.n && cyc < 64) begin
      check($sformatf("%s drain in_ready", v.name), ir(v.sel), 0);
      if (v.junk) drive_in(v.sel, 1'b1, 99, 1'b1);
      if (stalled) begin
        check($sformatf("%s stall data hold", v.name), od(v.sel), prev_d);
        check($sformatf("%s stall last hold", v.name), ol(v.sel), prev_l);
      end
      if (ov(v.sel) && rdy) begin
        check($sformatf("%s out_data[%0d]", v.name, k), od(v.sel), v.dout[k]);
        check($sformatf("%s out_last[%0d]", v.name, k), ol(v.sel), (k == v.n - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = ov(v.sel);
        prev_d  = od(v.sel);
        prev_l  = ol(v.sel);
      end
      @(posedge clk); #1;
      drive_in(v.sel, 1'b0, 0, 1'b0);
      cyc++;
      rdy = v.pat[cyc % 16];
      drive_rdy(v.sel, rdy);
      @(negedge clk);
    end
    if (k < v.n) check($sformatf("%s drain timeout, outputs seen", v.name), k, v.n);
    drive_rdy(v.sel, 1'b0);
    check($sformatf("%s bubble out_valid", v.name), ov(v.sel), 0);
    check($sformatf("%s bubble in_ready", v.name), ir(v.sel), 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic",        0, 4, '{3, -1, 7, 2},      1'b1, '{-4, -8, 0, -5},   16'hFFFF, 1'b0};
    vecs[1] = '{"single",       0, 1, '{5, 0, 0, 0},       1'b1, '{0, 0, 0, 0},      16'hFFFF, 1'b0};
    vecs[2] = '{"backpressure", 0, 3, '{10, 20, 15, 0},    1'b1, '{-10, 0, -5, 0},   16'hAAA9, 1'b1};
    vecs[3] = '{"all_equal",    0, 3, '{-6, -6, -6, 0},    1'b1, '{0, 0, 0, 0},      16'hFFFF, 1'b0};
    vecs[4] = '{"saturation",   1, 2, '{127, -128, 0, 0},  1'b1, '{0, -128, 0, 0},   16'hFFFF, 1'b0};
    vecs[5] = '{"forced_end",   1, 4, '{1, 2, 3, 4},       1'b0, '{-3, -2, -1, 0},   16'hFFFF, 1'b0};
    vecs[6] = '{"after_forced", 1, 1, '{-100, 0, 0, 0},    1'b1, '{0, 0, 0, 0},      16'hFFFF, 1'b0};

    rst = 1'b1;
    drive_in(0, 1'b0, 0, 1'b0);
    drive_in(1, 1'b0, 0, 1'b0);
    drive_rdy(0, 1'b0);
    drive_rdy(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset in_ready dut%0d", s),  ir(s), 0);
      check($sformatf("reset out_valid dut%0d", s), ov(s), 0);
      check($sformatf("reset out_data dut%0d", s),  od(s), 0);
      check($sformatf("reset out_last dut%0d", s),  ol(s), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // Reset after the first output handshake of {9,1,5}.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive_in(0, 1'b1, (i == 0) ? 9 : ((i == 1) ? 1 : 5), i == 2);
      @(posedge clk); #1;
    end
    drive_in(0, 1'b0, 0, 1'b0);
    drive_rdy(0, 1'b1);
    @(negedge clk);
    check("rst_mid first out_valid", ov(0), 1);
    check("rst_mid first out_data", od(0), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_rdy(0, 1'b0);
    @(negedge clk);
    check("rst_mid out_valid after reset", ov(0), 0);
    check("rst_mid out_data after reset", od(0), 0);
    check("rst_mid out_last after reset", ol(0), 0);
    check("rst_mid in_ready after reset", ir(0), 1);
    run_row('{"post_reset", 0, 1, '{2, 0, 0, 0}, 1'b1, '{0, 0, 0, 0}, 16'hFFFF, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max_subtract.md
Name: max_subtract

Overview:
- Softmax pre-stage for the I-BERT datapath.
- Accepts one row of signed integer scores as a valid/ready stream and buffers the whole row while tracking its running maximum.
- Once the row is complete, replays every buffered element as (x − row_max) on an output valid/ready stream; all outputs are ≤ 0, ready for the integer exponent stage.
- One row in flight at a time.

Parameters:
- D_W, 32, data width of input and output elements (signed two's complement).
- MAX_LEN, 64, maximum row length in elements; buffer depth.
- LEN_W, $clog2(MAX_LEN+1), width of the internal length/index counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  block can accept an input element.
- in_data  input  D_W  signed input element.
- in_last  input  1  marks the final element of the row.
- out_valid  output  1  output element valid.
- out_ready  input  1  downstream accepts the output element.
- out_data  output  D_W  signed (x − row_max), saturated.
- out_last  output  1  marks the final output element of the row.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port rst.
- States: S_FILL and S_DRAIN. Reset state is S_FILL.
- Reset values: out_valid=0, out_last=0, out_data=0, row_max=0, wr_cnt=0, rd_cnt=0. in_ready=0 while rst is high.
- S_FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: buffer[wr_cnt]<=in_data, wr_cnt++.
  - row_max<=in_data when wr_cnt==0; otherwise row_max<=max(row_max,in_data), signed compare.
- FILL→DRAIN: on the accepted beat with in_last=1, or on the accepted beat at wr_cnt==MAX_LEN−1 (forced end of row; any later in_last is treated as a new row).
  - At that edge, latch len=wr_cnt+1, clear rd_cnt and wr_cnt.
  - The final element's contribution is included in row_max before draining starts.
- Latency: first out_valid is asserted the cycle after the last input handshake.
- S_DRAIN:
  - in_ready=0.
  - out_valid=1, out_data=sat(buffer[rd_cnt]−row_max), out_last=(rd_cnt==len−1).
  - out_data is registered and advances only on out_valid&&out_ready.
  - While out_ready=0, out_data and out_last hold stable.
  - Throughput is one element per cycle under continuous out_ready.
- DRAIN→FILL: on the handshake with out_last=1.
  - The next cycle has out_valid=0 and in_ready=1, so there is one bubble between rows.
- Arithmetic:
  - Subtraction is computed at D_W+1 bits.
  - A result below −2^(D_W−1) saturates to −2^(D_W−1).
  - A positive result is impossible and needs no upper clamp.
- Boundaries:
  - A row of length 1 yields a single output 0 with out_last=1.
  - All-equal rows yield all zeros.
  - in_valid during S_DRAIN is ignored (not accepted).
- Reset mid-operation: rst in either state discards the partial row and buffered data. The next cycle is S_FILL with counters cleared, and no spurious out_valid.

Decomposition:
- Shared package softmax_pkg holds:
  - state_t enum {S_FILL, S_DRAIN};
  - function sat_sub(a,b) performing the D_W+1-bit subtract with lower saturation;
  - localparam defaults for D_W and MAX_LEN, shared with the downstream exponent stage.
- One natural sub-module, row_buffer: MAX_LEN×D_W register array with synchronous write port and asynchronous read by index, no reset on contents. FSM, counters and max tracking stay in max_subtract.

Test Plan:
- Basic row: D_W=32, inputs {3,−1,7,2} with in_last on 2, out_ready=1 → outputs {−4,−8,0,−5}. out_last on the 4th only. First out_valid one cycle after the last input handshake.
- Single element: input {5} with in_last → one output 0 with out_last=1; in_ready=1 again two cycles after the input handshake.
- Backpressure: row {10,20,15}; out_ready toggles 1,0,0,1,0,1… → outputs {−10,0,−5} in order. out_data stable during each stall. No drops or duplicates.
- Saturation: D_W=8, row {127,−128} → outputs {0,−128}, since −255 saturates to −128.
- Forced end: MAX_LEN=4, feed 4 elements {1,2,3,4} with in_last=0 → drain {−3,−2,−1,0} with out_last on the 4th. in_ready=0 throughout the drain.
- Reset mid-drain: row {9,1,5}; assert rst after the first output handshake → out_valid=0 the next cycle. A new row {2} then yields {0} with out_last=1, with no stale data.
